wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave bus. A stall
// timeout aborts a hung transfer and returns a one-cycle error to the owner.
module wb_rr_arbiter #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 128,
  parameter int TO = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NM*AW-1:0]      m_wb_adr,
  input  logic [NM*(DW/8)-1:0]  m_wb_sel,
  input  logic [NM-1:0]         m_wb_we,
  input  logic [NM*DW-1:0]      m_wb_dat_i,
  output logic [NM*DW-1:0]      m_wb_dat_o,
  input  logic [NM-1:0]         m_wb_cyc,
  input  logic [NM-1:0]         m_wb_stb,
  output logic [NM-1:0]         m_wb_ack,
  output logic [NM-1:0]         m_wb_err,
  output logic [AW-1:0]         s_wb_adr,
  output logic [(DW/8)-1:0]     s_wb_sel,
  output logic                  s_wb_we,
  output logic [DW-1:0]         s_wb_dat_o,
  input  logic [DW-1:0]         s_wb_dat_i,
  output logic                  s_wb_cyc,
  output logic                  s_wb_stb,
  input  logic                  s_wb_ack,
  input  logic                  s_wb_err,
  output logic [NM-1:0]         o_grant
);

  localparam int SW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          in_own, in_abort;
  logic          own_cyc, own_stb;
  logic          win_found;
  logic [IW-1:0] win_idx;
  int            cand;

  logic [AW-1:0] adr_arr [NM];
  logic [SW-1:0] sel_arr [NM];
  logic [DW-1:0] dat_arr [NM];

  assign in_own   = (state_q == ST_OWN);
  assign in_abort = (state_q == ST_ABORT);

  // last_q doubles as the current owner's index while a grant is held
  for (genvar gi = 0; gi < NM; gi++) begin : g_master
    assign adr_arr[gi] = m_wb_adr[gi*AW +: AW];
    assign sel_arr[gi] = m_wb_sel[gi*SW +: SW];
    assign dat_arr[gi] = m_wb_dat_i[gi*DW +: DW];
    assign m_wb_ack[gi] = in_own & grant_q[gi] & s_wb_ack;
    assign m_wb_err[gi] = grant_q[gi] & ((in_own & s_wb_err) | in_abort);
    assign m_wb_dat_o[gi*DW +: DW] = (in_own & grant_q[gi]) ? s_wb_dat_i : '0;
  end

  assign own_cyc = m_wb_cyc[last_q];
  assign own_stb = m_wb_stb[last_q];

  assign s_wb_cyc   = in_own & own_cyc;
  assign s_wb_stb   = in_own & own_stb;
  assign s_wb_we    = in_own & m_wb_we[last_q];
  assign s_wb_adr   = in_own ? adr_arr[last_q] : '0;
  assign s_wb_sel   = in_own ? sel_arr[last_q] : '0;
  assign s_wb_dat_o = in_own ? dat_arr[last_q] : '0;
  assign o_grant    = grant_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = 0;
    for (int k = 1; k <= NM; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NM) cand = cand - NM;
      if (!win_found && m_wb_cyc[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_OWN;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
          cnt_d            = '0;
        end
      end
      ST_OWN: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (s_wb_ack || s_wb_err) begin
          cnt_d = '0;
        end else if (own_stb) begin
          // a response in the same cycle takes the branch above, so it wins
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TO)) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic              clk;
  logic              rst_n;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*SW-1:0]  m_sel;
  logic [NM-1:0]     m_we;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM-1:0]     m_cyc;
  logic [NM-1:0]     m_stb;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_err;
  logic [AW-1:0]     s_adr;
  logic [SW-1:0]     s_sel;
  logic              s_we;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_cyc;
  logic              s_stb;
  logic              s_ack;
  logic              s_err;
  logic [NM-1:0]     o_grant;

  int n_tests = 0;
  int n_fail  = 0;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TO(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_wb_adr   (m_adr),
    .m_wb_sel   (m_sel),
    .m_wb_we    (m_we),
    .m_wb_dat_i (m_dat_i),
    .m_wb_dat_o (m_dat_o),
    .m_wb_cyc   (m_cyc),
    .m_wb_stb   (m_stb),
    .m_wb_ack   (m_ack),
    .m_wb_err   (m_err),
    .s_wb_adr   (s_adr),
    .s_wb_sel   (s_sel),
    .s_wb_we    (s_we),
    .s_wb_dat_o (s_dat_o),
    .s_wb_dat_i (s_dat_i),
    .s_wb_cyc   (s_cyc),
    .s_wb_stb   (s_stb),
    .s_wb_ack   (s_ack),
    .s_wb_err   (s_err),
    .o_grant    (o_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 when nobody holds the bus; mdl_abort marks the error cycle
  int mdl_owner;
  bit mdl_abort;
  int mdl_last;
  int mdl_stall;

  function automatic int rr_pick(input int last, input logic [NM-1:0] cyc);
    for (int k = 1; k <= NM; k++)
      if (cyc[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_owner <= -1;
      mdl_abort <= 1'b0;
      mdl_last  <= NM - 1;
      mdl_stall <= 0;
    end else if (mdl_abort) begin
      mdl_owner <= -1;
      mdl_abort <= 1'b0;
    end else if (mdl_owner < 0) begin
      if (rr_pick(mdl_last, m_cyc) >= 0) begin
        mdl_owner <= rr_pick(mdl_last, m_cyc);
        mdl_last  <= rr_pick(mdl_last, m_cyc);
        mdl_stall <= 0;
      end
    end else if (!m_cyc[mdl_owner]) begin
      mdl_owner <= -1;
    end else if (s_ack || s_err) begin
      mdl_stall <= 0;
    end else if (m_stb[mdl_owner]) begin
      mdl_stall <= mdl_stall + 1;
      if (mdl_stall + 1 == TO) mdl_abort <= 1'b1;
    end
  end

  logic [NM-1:0] e_grant, e_ack, e_err;
  logic [NM*DW-1:0] e_mdat;
  logic [AW-1:0] e_adr;
  logic [SW-1:0] e_sel;
  logic [DW-1:0] e_sdat;
  logic e_cyc, e_stb, e_we;

  always @(negedge clk) begin
    e_grant = '0; e_ack = '0; e_err = '0; e_mdat = '0;
    e_adr = '0; e_sel = '0; e_sdat = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    if (rst_n && mdl_owner >= 0) begin
      e_grant[mdl_owner] = 1'b1;
      if (mdl_abort) begin
        e_err[mdl_owner] = 1'b1;
      end else begin
        e_cyc = m_cyc[mdl_owner];
        e_stb = m_stb[mdl_owner];
        e_we  = m_we[mdl_owner];
        e_adr = m_adr[mdl_owner*AW +: AW];
        e_sel = m_sel[mdl_owner*SW +: SW];
        e_sdat = m_dat_i[mdl_owner*DW +: DW];
        e_ack[mdl_owner] = s_ack;
        e_err[mdl_owner] = s_err;
        e_mdat[mdl_owner*DW +: DW] = s_dat_i;
      end
    end
    chk("mdl_grant", o_grant, e_grant);
    chk("mdl_s_cyc", s_cyc, e_cyc);
    chk("mdl_s_stb", s_stb, e_stb);
    chk("mdl_s_we", s_we, e_we);
    chk("mdl_s_adr", s_adr, e_adr);
    chk("mdl_s_sel", s_sel, e_sel);
    chk("mdl_s_dat", s_dat_o, e_sdat);
    chk("mdl_m_ack", m_ack, e_ack);
    chk("mdl_m_err", m_err, e_err);
    chk("mdl_m_dat", m_dat_o, e_mdat);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
  endtask

  function automatic logic [DW-1:0] rand_dat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst_n = 1'b0;
    m_adr = '0; m_sel = '0; m_we = '0; m_dat_i = '0; m_cyc = '0; m_stb = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;

    repeat (3) step();
    #1 chk("rst_grant", o_grant, 0);
    chk("rst_cyc", s_cyc, 0);
    rst_n = 1'b1;
    step(); #1 chk("idle_grant", o_grant, 0);

    // both masters request: master 0 first, 3 beats, dead cycle, then master 1
    set_m(0, 1, 1); set_m(1, 1, 1);
    step(); #1 chk("a_grant0", o_grant, 2'b01);
    chk("a_cyc", s_cyc, 1);
    s_ack = 1'b1; s_dat_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    #1 chk("a_ack0", m_ack, 2'b01);
    chk("a_dat0", m_dat_o[0 +: DW], 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    chk("a_dat1", m_dat_o[DW +: DW], 0);
    repeat (3) step();
    set_m(0, 0, 0); s_ack = 1'b0;
    step(); #1 chk("a_dead", o_grant, 0);
    step(); #1 chk("a_grant1", o_grant, 2'b10);
    $display("[TB] scenario round-robin handoff complete");

    // master 0 waits while master 1 owns, granted two cycles after release
    s_ack = 1'b1; set_m(0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step(); #1 chk("b_wait_ack", m_ack, 2'b10);
      chk("b_hold_grant", o_grant, 2'b10);
    end
    set_m(1, 0, 0); s_ack = 1'b0;
    step(); #1 chk("b_dead", o_grant, 0);
    step(); #1 chk("b_grant0", o_grant, 2'b01);
    $display("[TB] scenario waiting master complete");

    // write passthrough from master 0
    m_we[0] = 1'b1;
    m_adr[0 +: AW] = 32'h0100_0010;
    m_sel[0 +: SW] = 16'h000F;
    m_dat_i[0 +: DW] = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
    s_ack = 1'b1;
    #1 chk("c_adr", s_adr, 32'h0100_0010);
    chk("c_sel", s_sel, 16'h000F);
    chk("c_we", s_we, 1);
    chk("c_dat", s_dat_o, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF);
    chk("c_ack", m_ack, 2'b01);
    step();
    $display("[TB] scenario write passthrough complete");

    // slave never answers: abort after TO stalled cycles
    s_ack = 1'b0; set_m(1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(); #1 chk("d_stall_cyc", s_cyc, 1);
      chk("d_no_err", m_err, 0);
    end
    step(); #1 chk("d_abort_cyc", s_cyc, 0);
    chk("d_abort_stb", s_stb, 0);
    chk("d_err", m_err, 2'b01);
    chk("d_abort_grant", o_grant, 2'b01);
    step(); #1 chk("d_err_once", m_err, 0);
    chk("d_idle_grant", o_grant, 0);
    step(); #1 chk("d_next_grant", o_grant, 2'b10);
    $display("[TB] scenario timeout abort complete");

    // ack on the TO-th stalled cycle wins over the timeout
    set_m(0, 0, 0);
    repeat (3) step();
    s_ack = 1'b1;
    #1 chk("e_ack", m_ack, 2'b10);
    chk("e_no_err", m_err, 0);
    step(); #1 chk("e_cyc", s_cyc, 1);
    chk("e_grant", o_grant, 2'b10);
    chk("e_err", m_err, 0);
    $display("[TB] scenario late ack complete");

    // reset mid-transfer
    s_ack = 1'b0; set_m(0, 1, 1);
    rst_n = 1'b0;
    #1 chk("f_cyc", s_cyc, 0);
    chk("f_grant", o_grant, 0);
    chk("f_ack", m_ack, 0);
    chk("f_err", m_err, 0);
    step(); rst_n = 1'b1;
    step(); #1 chk("f_first_grant", o_grant, 2'b01);
    $display("[TB] scenario reset mid-transfer complete");

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NM; i++) begin
        if (!m_cyc[i]) begin
          if ($urandom_range(0, 3) == 0) m_cyc[i] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          m_cyc[i] = 1'b0;
        end
        m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
        m_we[i]  = 1'($urandom_range(0, 1));
        m_adr[i*AW +: AW] = $urandom();
        m_sel[i*SW +: SW] = SW'($urandom());
        m_dat_i[i*DW +: DW] = rand_dat();
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 11) == 0);
      s_dat_i = rand_dat();
      rst_n   = (c != 1500);
    end
    $display("[TB] scenario random traffic complete");

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
